capture_sequencer: RTL and testbench

Single-clock control block for the synchronous capture storage. It arms on a host start command and waits for an acoustic trigger on channel A, or for a timeout. It then drives load until the storage reports full, and sequences readout channel by channel. For readout it steps the channel-select bits and issues one read-enable pulse per host word request. It sits between the host/USB readout logic and the storage block, and drives that block's load, rdenA and cntrl_bits inputs.

---
 rtl/capture_sequencer_if.sv | 54 +++++
 rtl/capture_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_capture_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/capture_sequencer_if.sv
// ---------------------------------------------------------------------------
// capture_sequencer_if
// Bundles the host command/readout signals and the storage control signals
// of the capture sequencer.
//   master modport : host side. Drives the commands, trigger setup, sample
//                    stream, storage full flag and word requests. Observes
//                    the storage controls and status.
//   slave modport  : the sequencer itself.
// Signals:
//   start, abort, force_trig    one-cycle command pulses
//   trig_thresh[13:0]           unsigned magnitude threshold
//   timeout[TIMEOUT_BITS-1:0]   ARM timeout in cycles, 0 = wait forever
//   din_a[13:0], dec_rdy        channel A sample and its valid strobe
//   full                        storage full flag
//   host_req                    level, host wants the next word
//   load, rden_a, cntrl_bits    storage write enable, read advance, channel select
//   word_valid                  storage dout valid strobe
//   busy, done, trig_src, state_o  status
// ---------------------------------------------------------------------------
interface capture_sequencer_if #(
    parameter int TIMEOUT_BITS = 24
);
    logic                    start;
    logic                    abort;
    logic                    force_trig;
    logic [13:0]             trig_thresh;
    logic [TIMEOUT_BITS-1:0] timeout;
    logic [13:0]             din_a;
    logic                    dec_rdy;
    logic                    full;
    logic                    host_req;
    logic                    load;
    logic                    rden_a;
    logic [2:0]              cntrl_bits;
    logic                    word_valid;
    logic                    busy;
    logic                    done;
    logic                    trig_src;
    logic [2:0]              state_o;

    modport master (
        output start, abort, force_trig, trig_thresh, timeout,
               din_a, dec_rdy, full, host_req,
        input  load, rden_a, cntrl_bits, word_valid,
               busy, done, trig_src, state_o
    );

    modport slave (
        input  start, abort, force_trig, trig_thresh, timeout,
               din_a, dec_rdy, full, host_req,
        output load, rden_a, cntrl_bits, word_valid,
               busy, done, trig_src, state_o
    );
endinterface

// File: rtl/capture_sequencer.sv
// ---------------------------------------------------------------------------
// capture_sequencer
// Control block for the synchronous capture storage. Arms on start, waits
// for a channel A threshold trigger (or a forced/timeout trigger), drives
// load until the storage reports full, then reads the storage out channel
// by channel, issuing one rden_a pulse per host word request and flagging
// the returned word with word_valid RD_LAT cycles later.
// Ports:
//   clk    system clock (also the storage clock)
//   rst_n  asynchronous active-low reset
//   bus    capture_sequencer_if.slave, all command/storage/status signals
// ---------------------------------------------------------------------------
module capture_sequencer #(
    parameter int NUM_CH       = 8,
    parameter int DEPTH_BITS   = 13,
    parameter int SETTLE_CYC   = 4,
    parameter int RD_LAT       = 2,
    parameter int TIMEOUT_BITS = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    capture_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SELECT  = 3'd3,
        ST_READ    = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam int                     SET_W       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [DEPTH_BITS-1:0]  WORD_MAX    = {DEPTH_BITS{1'b1}};
    localparam logic [2:0]             LAST_CH     = 3'(NUM_CH - 1);
    localparam logic [SET_W-1:0]       SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
    // Every latency stage except the last one. The last stage is the
    // word_valid cycle, in which the next read is allowed to be issued.
    localparam logic [RD_LAT-1:0]      EARLY_MASK  = {RD_LAT{1'b1}} >> 1;

    state_t                  state_reg, state_next;
    logic [TIMEOUT_BITS-1:0] tmo_cnt_reg, tmo_cnt_next;
    logic                    load_reg, load_next;
    logic                    rden_reg, rden_next;
    logic [RD_LAT-1:0]       pipe_reg, pipe_next, pipe_shift;
    logic [DEPTH_BITS-1:0]   word_cnt_reg, word_cnt_next;
    logic [2:0]              chan_reg, chan_next;
    logic [2:0]              cntrl_reg, cntrl_next;
    logic [SET_W-1:0]        settle_reg, settle_next;
    logic                    trig_src_reg, trig_src_next;

    logic [13:0]             din_neg, din_mag;
    logic [TIMEOUT_BITS-1:0] tmo_inc;
    logic                    thresh_hit, forced_hit, in_flight, word_valid;

    // |din_a| as unsigned; -8192 has no positive counterpart and saturates.
    assign din_neg = 14'd0 - bus.din_a;
    always_comb begin
        din_mag = bus.din_a;
        if (bus.din_a[13]) begin
            din_mag = (bus.din_a == 14'h2000) ? 14'h1FFF : din_neg;
        end
    end

    assign thresh_hit = bus.dec_rdy && (din_mag >= bus.trig_thresh);
    // The counter reaches the timeout value on the same edge that leaves ARM,
    // so CAPTURE starts exactly 'timeout' cycles after ARM entry.
    assign tmo_inc    = tmo_cnt_reg + TIMEOUT_BITS'(1);
    assign forced_hit = bus.force_trig || ((bus.timeout != '0) && (tmo_inc == bus.timeout));

    // Read latency shift register: stage 0 follows rden_a, the last stage is word_valid.
    assign pipe_shift[0] = rden_reg;
    for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_pipe
        assign pipe_shift[gi] = pipe_reg[gi-1];
    end

    assign word_valid = pipe_reg[RD_LAT-1];
    assign in_flight  = rden_reg || ((pipe_reg & EARLY_MASK) != '0);

    always_comb begin
        state_next    = state_reg;
        tmo_cnt_next  = tmo_cnt_reg;
        load_next     = load_reg;
        rden_next     = 1'b0;
        pipe_next     = pipe_shift;
        word_cnt_next = word_cnt_reg;
        chan_next     = chan_reg;
        cntrl_next    = cntrl_reg;
        settle_next   = settle_reg;
        trig_src_next = trig_src_reg;

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_next   = ST_ARM;
                    tmo_cnt_next = '0;
                end
            end
            ST_ARM: begin
                tmo_cnt_next = tmo_inc;
                // Threshold wins over forced/timeout in the same cycle.
                if (thresh_hit) begin
                    state_next    = ST_CAPTURE;
                    trig_src_next = 1'b0;
                end else if (forced_hit) begin
                    state_next    = ST_CAPTURE;
                    trig_src_next = 1'b1;
                end
            end
            ST_CAPTURE: begin
                // full only counts once load is high, so load always pulses
                // for at least one cycle even if full is already set.
                if (load_reg && bus.full) begin
                    load_next   = 1'b0;
                    state_next  = ST_SELECT;
                    chan_next   = 3'd0;
                    cntrl_next  = 3'd0;
                    settle_next = '0;
                end else begin
                    load_next = 1'b1;
                end
            end
            ST_SELECT: begin
                if (settle_reg == SETTLE_LAST) begin
                    state_next    = ST_READ;
                    word_cnt_next = '0;
                    settle_next   = '0;
                end else begin
                    settle_next = settle_reg + SET_W'(1);
                end
            end
            ST_READ: begin
                if (bus.host_req && !in_flight && (word_cnt_reg != WORD_MAX)) begin
                    rden_next     = 1'b1;
                    word_cnt_next = word_cnt_reg + DEPTH_BITS'(1);
                end
                // word_cnt counts issued reads, so it already equals WORD_MAX
                // when the last word of the channel comes back.
                if (word_valid && (word_cnt_reg == WORD_MAX)) begin
                    if (chan_reg != LAST_CH) begin
                        chan_next   = chan_reg + 3'd1;
                        cntrl_next  = chan_reg + 3'd1;
                        settle_next = '0;
                        state_next  = ST_SELECT;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (bus.abort) begin
            state_next    = ST_IDLE;
            tmo_cnt_next  = '0;
            load_next     = 1'b0;
            rden_next     = 1'b0;
            pipe_next     = '0;
            word_cnt_next = '0;
            chan_next     = 3'd0;
            cntrl_next    = 3'd0;
            settle_next   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            tmo_cnt_reg  <= '0;
            load_reg     <= 1'b0;
            rden_reg     <= 1'b0;
            pipe_reg     <= '0;
            word_cnt_reg <= '0;
            chan_reg     <= 3'd0;
            cntrl_reg    <= 3'd0;
            settle_reg   <= '0;
            trig_src_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tmo_cnt_reg  <= tmo_cnt_next;
            load_reg     <= load_next;
            rden_reg     <= rden_next;
            pipe_reg     <= pipe_next;
            word_cnt_reg <= word_cnt_next;
            chan_reg     <= chan_next;
            cntrl_reg    <= cntrl_next;
            settle_reg   <= settle_next;
            trig_src_reg <= trig_src_next;
        end
    end

    assign bus.load       = load_reg;
    assign bus.rden_a     = rden_reg;
    assign bus.cntrl_bits = cntrl_reg;
    assign bus.word_valid = word_valid;
    assign bus.busy       = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
    assign bus.done       = (state_reg == ST_DONE);
    assign bus.trig_src   = trig_src_reg;
    assign bus.state_o    = state_reg;

endmodule

// File: tb/tb_capture_sequencer.sv
// ---------------------------------------------------------------------------
// tb_capture_sequencer
// Directed self-checking bench for capture_sequencer, built with a small
// storage geometry (4 channels of 15 words) so a full readout is short.
// ---------------------------------------------------------------------------
module tb_capture_sequencer;

    localparam int NUM_CH       = 4;
    localparam int DEPTH_BITS   = 4;
    localparam int SETTLE_CYC   = 4;
    localparam int RD_LAT       = 2;
    localparam int TIMEOUT_BITS = 24;
    localparam int WORDS        = 15;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    capture_sequencer_if #(.TIMEOUT_BITS(TIMEOUT_BITS)) bus ();

    capture_sequencer #(
        .NUM_CH      (NUM_CH),
        .DEPTH_BITS  (DEPTH_BITS),
        .SETTLE_CYC  (SETTLE_CYC),
        .RD_LAT      (RD_LAT),
        .TIMEOUT_BITS(TIMEOUT_BITS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic pulse_abort();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
    endtask

    function automatic logic [11:0] all_outs();
        return {bus.load, bus.rden_a, bus.word_valid, bus.done, bus.busy,
                bus.trig_src, bus.cntrl_bits, bus.state_o};
    endfunction

    task automatic test_reset();
        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.force_trig  = 1'b0;
        bus.trig_thresh = 14'd0;
        bus.timeout     = '0;
        bus.din_a       = 14'd0;
        bus.dec_rdy     = 1'b0;
        bus.full        = 1'b0;
        bus.host_req    = 1'b0;
        repeat (3) tick();
        checks++;
        if (all_outs() !== 12'h000) begin
            errors++; $display("FAIL reset_outputs got %h exp 000", all_outs());
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (all_outs() !== 12'h000) begin
            errors++; $display("FAIL reset_release got %h exp 000", all_outs());
        end
        $display("test_reset: complete");
    endtask

    task automatic test_threshold();
        bus.trig_thresh = 14'd1000;
        bus.timeout     = '0;
        pulse_start();
        checks++;
        if (bus.state_o !== 3'd1) begin errors++; $display("FAIL arm_entry got %0d exp 1", bus.state_o); end
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL arm_busy got %b exp 1", bus.busy); end
        bus.din_a = 14'd1200; bus.dec_rdy = 1'b0;
        tick();
        checks++;
        if (bus.state_o !== 3'd1) begin errors++; $display("FAIL no_strobe got %0d exp 1", bus.state_o); end
        bus.din_a = 14'(-999); bus.dec_rdy = 1'b1;
        tick();
        checks++;
        if (bus.state_o !== 3'd1) begin errors++; $display("FAIL below_thresh got %0d exp 1", bus.state_o); end
        bus.din_a = 14'(-1200);
        tick();
        bus.dec_rdy = 1'b0;
        checks++;
        if (bus.state_o !== 3'd2) begin errors++; $display("FAIL thresh_trig got %0d exp 2", bus.state_o); end
        checks++;
        if (bus.trig_src !== 1'b0) begin errors++; $display("FAIL thresh_src got %b exp 0", bus.trig_src); end
        checks++;
        if (bus.load !== 1'b0) begin errors++; $display("FAIL load_entry got %b exp 0", bus.load); end
        tick();
        checks++;
        if (bus.load !== 1'b1) begin errors++; $display("FAIL load_rise got %b exp 1", bus.load); end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.state_o !== 3'd2) begin errors++; $display("FAIL start_ignored got %0d exp 2", bus.state_o); end
        $display("test_threshold: complete");
    endtask

    task automatic test_capture_full();
        int bad = 0;
        for (int i = 0; i < 8191; i++) begin
            bus.dec_rdy = 1'b1;
            tick();
            if (bus.load !== 1'b1 || bus.state_o !== 3'd2) bad++;
        end
        bus.dec_rdy = 1'b0;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL load_hold got %0d bad cycles exp 0", bad); end
        bus.full = 1'b1;
        tick();
        bus.full = 1'b0;
        checks++;
        if (bus.load !== 1'b0) begin errors++; $display("FAIL full_load got %b exp 0", bus.load); end
        checks++;
        if (bus.state_o !== 3'd3) begin errors++; $display("FAIL full_select got %0d exp 3", bus.state_o); end
        checks++;
        if (bus.cntrl_bits !== 3'd0) begin errors++; $display("FAIL select_ch0 got %0d exp 0", bus.cntrl_bits); end
        $display("test_capture_full: complete");
    endtask

    task automatic test_readout();
        int last_sel = 0;
        int last_rd  = -100;
        int rd_total = 0;
        int wv_total = 0;
        logic [2:0] last_state = 3'd3;
        bus.host_req = 1'b1;
        for (int cyc = 1; cyc <= 2000 && bus.done !== 1'b1; cyc++) begin
            tick();
            if (bus.state_o === 3'd3 && last_state !== 3'd3) last_sel = cyc;
            last_state = bus.state_o;
            if (bus.word_valid === 1'b1) begin
                wv_total++;
                checks++;
                if (cyc - last_rd !== 2) begin
                    errors++; $display("FAIL wv_latency got %0d exp 2", cyc - last_rd);
                end
            end
            if (bus.rden_a === 1'b1) begin
                checks++;
                if (bus.cntrl_bits !== 3'(rd_total / WORDS)) begin
                    errors++; $display("FAIL rd_channel got %0d exp %0d", bus.cntrl_bits, rd_total / WORDS);
                end
                checks++;
                if (rd_total % WORDS == 0) begin
                    if (cyc - last_sel < SETTLE_CYC) begin
                        errors++; $display("FAIL settle got %0d exp >=%0d", cyc - last_sel, SETTLE_CYC);
                    end
                end else if (cyc - last_rd !== 3) begin
                    errors++; $display("FAIL rd_spacing got %0d exp 3", cyc - last_rd);
                end
                last_rd = cyc;
                rd_total++;
            end
        end
        bus.host_req = 1'b0;
        checks++;
        if (bus.done !== 1'b1) begin errors++; $display("FAIL readout_done got %b exp 1", bus.done); end
        checks++;
        if (rd_total !== NUM_CH * WORDS) begin errors++; $display("FAIL rd_count got %0d exp %0d", rd_total, NUM_CH * WORDS); end
        checks++;
        if (wv_total !== NUM_CH * WORDS) begin errors++; $display("FAIL wv_count got %0d exp %0d", wv_total, NUM_CH * WORDS); end
        checks++;
        if (bus.cntrl_bits !== 3'd3) begin errors++; $display("FAIL done_ch got %0d exp 3", bus.cntrl_bits); end
        checks++;
        if (bus.state_o !== 3'd5 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL done_state got %0d busy %b exp 5 busy 0", bus.state_o, bus.busy);
        end
        checks++;
        if (bus.trig_src !== 1'b0) begin errors++; $display("FAIL done_src got %b exp 0", bus.trig_src); end
        $display("test_readout: %0d reads %0d words", rd_total, wv_total);
    endtask

    task automatic test_timeout();
        int n = 0;
        int bad = 0;
        bus.timeout = 24'd50;
        pulse_start();
        checks++;
        if (bus.state_o !== 3'd1 || bus.done !== 1'b0) begin
            errors++; $display("FAIL done_to_arm got state %0d done %b exp 1 0", bus.state_o, bus.done);
        end
        while (bus.state_o !== 3'd2 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 50) begin errors++; $display("FAIL timeout_cycles got %0d exp 50", n); end
        checks++;
        if (bus.trig_src !== 1'b1) begin errors++; $display("FAIL timeout_src got %b exp 1", bus.trig_src); end
        pulse_abort();
        checks++;
        if (bus.state_o !== 3'd0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL abort_capture got %0d exp 0", bus.state_o);
        end
        bus.timeout = '0;
        pulse_start();
        for (int i = 0; i < 10000; i++) begin
            tick();
            if (bus.state_o !== 3'd1) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL wait_forever got %0d bad cycles exp 0", bad); end
        bus.force_trig = 1'b1;
        tick();
        bus.force_trig = 1'b0;
        checks++;
        if (bus.state_o !== 3'd2 || bus.trig_src !== 1'b1) begin
            errors++; $display("FAIL force_trig got %0d src %b exp 2 src 1", bus.state_o, bus.trig_src);
        end
        pulse_abort();
        bus.trig_thresh = 14'd1000;
        pulse_start();
        bus.din_a = 14'd1500; bus.dec_rdy = 1'b1; bus.force_trig = 1'b1;
        tick();
        bus.dec_rdy = 1'b0; bus.force_trig = 1'b0;
        checks++;
        if (bus.state_o !== 3'd2 || bus.trig_src !== 1'b0) begin
            errors++; $display("FAIL both_trig got %0d src %b exp 2 src 0", bus.state_o, bus.trig_src);
        end
        $display("test_timeout: complete");
    endtask

    task automatic test_saturation();
        pulse_abort();
        pulse_start();
        bus.trig_thresh = 14'd8192; bus.din_a = 14'h2000; bus.dec_rdy = 1'b1;
        tick();
        checks++;
        if (bus.state_o !== 3'd1) begin errors++; $display("FAIL sat_below got %0d exp 1", bus.state_o); end
        bus.trig_thresh = 14'd8191;
        tick();
        bus.dec_rdy = 1'b0;
        checks++;
        if (bus.state_o !== 3'd2 || bus.trig_src !== 1'b0) begin
            errors++; $display("FAIL sat_equal got %0d src %b exp 2 src 0", bus.state_o, bus.trig_src);
        end
        $display("test_saturation: complete");
    endtask

    task automatic test_full_on_entry();
        pulse_abort();
        bus.full = 1'b1;
        pulse_start();
        bus.force_trig = 1'b1;
        tick();
        bus.force_trig = 1'b0;
        checks++;
        if (bus.state_o !== 3'd2 || bus.load !== 1'b0) begin
            errors++; $display("FAIL fe_entry got %0d load %b exp 2 load 0", bus.state_o, bus.load);
        end
        tick();
        checks++;
        if (bus.state_o !== 3'd2 || bus.load !== 1'b1) begin
            errors++; $display("FAIL fe_pulse got %0d load %b exp 2 load 1", bus.state_o, bus.load);
        end
        tick();
        bus.full = 1'b0;
        checks++;
        if (bus.state_o !== 3'd3 || bus.load !== 1'b0) begin
            errors++; $display("FAIL fe_exit got %0d load %b exp 3 load 0", bus.state_o, bus.load);
        end
        $display("test_full_on_entry: complete");
    endtask

    task automatic test_abort();
        int n = 0;
        int bad = 0;
        bus.host_req = 1'b1;
        while (bus.rden_a !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (bus.rden_a !== 1'b1) begin errors++; $display("FAIL abort_rden got %b exp 1", bus.rden_a); end
        bus.host_req = 1'b0;
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checks++;
        if (bus.state_o !== 3'd0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL abort_idle got %0d busy %b exp 0 busy 0", bus.state_o, bus.busy);
        end
        checks++;
        if (bus.word_valid !== 1'b0 || bus.rden_a !== 1'b0 || bus.cntrl_bits !== 3'd0) begin
            errors++; $display("FAIL abort_outs got wv %b rd %b ch %0d exp 0 0 0", bus.word_valid, bus.rden_a, bus.cntrl_bits);
        end
        repeat (4) begin
            tick();
            if (bus.word_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL abort_suppress got %0d strobes exp 0", bad); end
        $display("test_abort: complete");
    endtask

    task automatic test_reset_mid_read();
        int n = 0;
        pulse_start();
        bus.full = 1'b1; bus.force_trig = 1'b1;
        tick();
        bus.force_trig = 1'b0;
        bus.host_req = 1'b1;
        while (!(bus.state_o === 3'd4 && bus.cntrl_bits === 3'd3) && n < 2000) begin
            tick();
            n++;
        end
        checks++;
        if (bus.state_o !== 3'd4 || bus.cntrl_bits !== 3'd3) begin
            errors++; $display("FAIL reach_ch3 got %0d ch %0d exp 4 ch 3", bus.state_o, bus.cntrl_bits);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (all_outs() !== 12'h000) begin
            errors++; $display("FAIL async_reset got %h exp 000", all_outs());
        end
        #2 rst_n = 1'b1;
        bus.host_req = 1'b0; bus.full = 1'b0;
        tick();
        pulse_start();
        checks++;
        if (bus.state_o !== 3'd1) begin errors++; $display("FAIL restart_arm got %0d exp 1", bus.state_o); end
        $display("test_reset_mid_read: complete");
    endtask

    initial begin
        test_reset();
        test_threshold();
        test_capture_full();
        test_readout();
        test_timeout();
        test_saturation();
        test_full_on_entry();
        test_abort();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
